// File: rtl/adc_channel_sequencer.sv
// adc_channel_sequencer: schedules single conversions on a 4-channel SPI ADC.
// Periodic all-channel scans and level-held per-channel requests are merged,
// served round-robin one channel at a time through the read engine, and the
// latest sample of every channel is kept in ch_data_o.
module adc_channel_sequencer #(
   parameter int NUM_CH      = 4,
   parameter int DATA_W      = 12,
   parameter int SCAN_PERIOD = 50000,
   parameter int TIMEOUT     = 16384,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     scan_en_i,
   input  logic [NUM_CH-1:0]        req_i,
   output logic [NUM_CH-1:0]        ack_o,
   output logic                     conv_start_o,
   output logic [CH_W-1:0]          conv_ch_o,
   input  logic                     conv_busy_i,
   input  logic                     conv_done_i,
   input  logic [DATA_W-1:0]        conv_data_i,
   output logic                     result_valid_o,
   output logic [CH_W-1:0]          result_ch_o,
   output logic [DATA_W-1:0]        result_data_o,
   output logic [NUM_CH*DATA_W-1:0] ch_data_o,
   output logic                     scan_miss_o,
   output logic                     err_timeout_o
);

   localparam int SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam int TMO_W  = $clog2(TIMEOUT + 1);

   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
   localparam logic [CH_W-1:0]   RR_INIT   = CH_W'(NUM_CH - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] GRANT = 3'd1;
   localparam logic [2:0] START = 3'd2;
   localparam logic [2:0] WAIT  = 3'd3;
   localparam logic [2:0] STORE = 3'd4;

   logic [2:0]               state_q, state_d;
   logic [SCAN_W-1:0]        scanCnt_q;
   logic [NUM_CH-1:0]        scanPend_q;
   logic [CH_W-1:0]          rrLast_q;
   logic [CH_W-1:0]          convCh_q;
   logic                     reqHit_q;
   logic [TMO_W-1:0]         timer_q;
   logic [DATA_W-1:0]        sample_q;
   logic                     convStart_q;
   logic [NUM_CH-1:0]        ack_q;
   logic                     resultValid_q;
   logic [CH_W-1:0]          resultCh_q;
   logic [DATA_W-1:0]        resultData_q;
   logic [NUM_CH*DATA_W-1:0] chData_q;
   logic                     scanMiss_q;
   logic                     errTimeout_q;

   logic                     scanTick;
   logic                     timeoutHit;
   logic [NUM_CH-1:0]        pending;
   logic [NUM_CH-1:0]        clrMask;
   logic                     grantFound;
   logic [CH_W-1:0]          grantCh;

   // A requester sees ack in the same cycle the FSM is back in IDLE, so that
   // channel's req is masked for one cycle; only a req still held after the
   // ack cycle counts as a fresh request.
   assign scanTick   = scan_en_i && (scanCnt_q == SCAN_LAST);
   assign timeoutHit = (state_q == WAIT) && !conv_done_i && (timer_q == TMO_LAST);
   assign pending    = (req_i & ~ack_q) | scanPend_q;
   assign clrMask    = ((state_q == STORE) || timeoutHit) ? (NUM_CH'(1) << convCh_q) : '0;

   // Round-robin search for the first pending channel after the last grant
   always_comb begin
      logic [CH_W-1:0] cand;
      cand       = '0;
      grantFound = 1'b0;
      grantCh    = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = CH_W'((int'(rrLast_q) + i) % NUM_CH);
         if (!grantFound && pending[cand]) begin
            grantFound = 1'b1;
            grantCh    = cand;
         end
      end
   end

   // Next-state logic; a conv_done in the last allowed cycle beats the timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|pending) state_d = GRANT;
         GRANT:   state_d = grantFound ? START : IDLE;
         START:   if (!conv_busy_i) state_d = WAIT;
         WAIT: begin
            if (conv_done_i)             state_d = STORE;
            else if (timer_q == TMO_LAST) state_d = IDLE;
         end
         STORE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Scan timer and pending-scan bits; a tick re-arms every channel and flags
   // an overrun if the previous pass still had channels outstanding
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scanCnt_q  <= '0;
         scanPend_q <= '0;
         scanMiss_q <= 1'b0;
      end else begin
         if (!scan_en_i || (scanCnt_q == SCAN_LAST)) scanCnt_q <= '0;
         else                                         scanCnt_q <= scanCnt_q + SCAN_W'(1);
         scanPend_q <= scanTick ? '1 : (scanPend_q & ~clrMask);
         scanMiss_q <= scanTick && (|scanPend_q);
      end
   end

   // FSM state plus every registered output and datapath register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         rrLast_q      <= RR_INIT;
         convCh_q      <= '0;
         reqHit_q      <= 1'b0;
         timer_q       <= '0;
         sample_q      <= '0;
         convStart_q   <= 1'b0;
         ack_q         <= '0;
         resultValid_q <= 1'b0;
         resultCh_q    <= '0;
         resultData_q  <= '0;
         chData_q      <= '0;
         errTimeout_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         convStart_q   <= 1'b0;
         ack_q         <= '0;
         resultValid_q <= 1'b0;
         errTimeout_q  <= 1'b0;
         case (state_q)
            GRANT: begin
               if (grantFound) begin
                  convCh_q <= grantCh;
                  rrLast_q <= grantCh;
                  reqHit_q <= req_i[grantCh];
               end
            end
            START: begin
               if (!conv_busy_i) begin
                  convStart_q <= 1'b1;
                  timer_q     <= '0;
               end
            end
            WAIT: begin
               if (conv_done_i)              sample_q     <= conv_data_i;
               else if (timer_q == TMO_LAST) errTimeout_q <= 1'b1;
               else                          timer_q      <= timer_q + TMO_W'(1);
            end
            STORE: begin
               resultValid_q    <= 1'b1;
               resultCh_q       <= convCh_q;
               resultData_q     <= sample_q;
               ack_q[convCh_q]  <= reqHit_q;
               for (int n = 0; n < NUM_CH; n++) begin
                  if (int'(convCh_q) == n) chData_q[n*DATA_W +: DATA_W] <= sample_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign ack_o          = ack_q;
   assign conv_start_o   = convStart_q;
   assign conv_ch_o      = convCh_q;
   assign result_valid_o = resultValid_q;
   assign result_ch_o    = resultCh_q;
   assign result_data_o  = resultData_q;
   assign ch_data_o      = chData_q;
   assign scan_miss_o    = scanMiss_q;
   assign err_timeout_o  = errTimeout_q;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// tb_adc_channel_sequencer: directed bench with a behavioural read engine.
// Inputs are driven 1 time unit after each rising edge; the engine model
// reacts on falling edges.
module tb_adc_channel_sequencer;

   localparam int NUM_CH      = 4;
   localparam int DATA_W      = 12;
   localparam int SCAN_PERIOD = 200;
   localparam int TIMEOUT     = 100;
   localparam int CH_W        = 2;

   typedef struct {
      logic [NUM_CH-1:0] req;
      int                latency;
      logic [DATA_W-1:0] data;
      logic [CH_W-1:0]   expCh;
   } vec_t;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     scan_en;
   logic [NUM_CH-1:0]        req;
   logic [NUM_CH-1:0]        ack;
   logic                     conv_start;
   logic [CH_W-1:0]          conv_ch;
   logic                     conv_busy;
   logic                     conv_done = 1'b0;
   logic [DATA_W-1:0]        conv_data = '0;
   logic                     result_valid;
   logic [CH_W-1:0]          result_ch;
   logic [DATA_W-1:0]        result_data;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic                     scan_miss;
   logic                     err_timeout;

   int checksTotal  = 0;
   int checksPassed = 0;
   int rvCount      = 0;
   int missCount    = 0;
   int errCount     = 0;
   int doneCount    = 0;

   logic              engRespond = 1'b1;
   int                engLatency = 5;
   logic [DATA_W-1:0] engData    = '0;
   int                engCnt     = 0;
   logic [CH_W-1:0]   startLog[$];
   logic [DATA_W-1:0] chModel[NUM_CH];
   vec_t              vecs[4];

   adc_channel_sequencer #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SCAN_PERIOD(SCAN_PERIOD), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .scan_en_i(scan_en), .req_i(req), .ack_o(ack),
      .conv_start_o(conv_start), .conv_ch_o(conv_ch), .conv_busy_i(conv_busy),
      .conv_done_i(conv_done), .conv_data_i(conv_data), .result_valid_o(result_valid),
      .result_ch_o(result_ch), .result_data_o(result_data), .ch_data_o(ch_data),
      .scan_miss_o(scan_miss), .err_timeout_o(err_timeout)
   );

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   // Read-engine model: logs every conv_start and answers after engLatency cycles
   always @(negedge clk) begin
      conv_done = 1'b0;
      if (conv_start) startLog.push_back(conv_ch);
      if (engCnt > 0) begin
         engCnt = engCnt - 1;
         if (engCnt == 0) begin
            conv_done = 1'b1;
            conv_data = engData;
            doneCount = doneCount + 1;
         end
      end else if (conv_start && engRespond) begin
         engCnt = engLatency;
      end
   end

   // Pulse counters used by the multi-cycle checks
   always @(negedge clk) begin
      if (result_valid) rvCount   = rvCount + 1;
      if (scan_miss)    missCount = missCount + 1;
      if (err_timeout)  errCount  = errCount + 1;
   end

   // Hang guard
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checksTotal = checksTotal + 1;
      if (actual == expected) checksPassed = checksPassed + 1;
      else $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyReset();
      rst_n     = 1'b0;
      req       = '0;
      scan_en   = 1'b0;
      conv_busy = 1'b0;
      for (int i = 0; i < NUM_CH; i++) chModel[i] = '0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   // Waits (bounded) until ack pulses; cycles = edges waited, bound+1 on expiry
   task automatic waitAck(input int bound, output int cycles, output logic [NUM_CH-1:0] seen);
      cycles = bound + 1;
      seen   = '0;
      for (int k = 1; k <= bound; k++) begin
         tick(1);
         if (ack != 0) begin
            cycles = k;
            seen   = ack;
            break;
         end
      end
   endtask

   task automatic waitStart(input int bound, output int cycles);
      cycles = bound + 1;
      for (int k = 1; k <= bound; k++) begin
         tick(1);
         if (conv_start) begin
            cycles = k;
            break;
         end
      end
   endtask

   function automatic logic [NUM_CH*DATA_W-1:0] packModel();
      logic [NUM_CH*DATA_W-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_CH; i++) v[i*DATA_W +: DATA_W] = chModel[i];
      return v;
   endfunction

   function automatic int orderErrors(input int base, input int n);
      int errs;
      errs = 0;
      if (startLog.size() < base + n) return n;
      for (int i = 0; i < n; i++) begin
         if (int'(startLog[base + i]) != (i % NUM_CH)) errs++;
      end
      return errs;
   endfunction

   task automatic applyStimulus(input vec_t v);
      int                cyc;
      int                base;
      logic [NUM_CH-1:0] seen;
      logic              rv;
      base       = startLog.size();
      engData    = v.data;
      engLatency = v.latency;
      engRespond = 1'b1;
      req        = v.req;
      waitAck(300, cyc, seen);
      rv  = result_valid;
      req = '0;
      chModel[v.expCh] = v.data;
      checkOutput("vecAck", longint'(seen), longint'(v.req));
      checkOutput("vecResultValid", longint'(rv), 1);
      checkOutput("vecResultCh", longint'(result_ch), longint'(v.expCh));
      checkOutput("vecResultData", longint'(result_data), longint'(v.data));
      checkOutput("vecChData", longint'(ch_data), longint'(packModel()));
      checkOutput("vecStartCh", (startLog.size() > base) ? longint'(startLog[base]) : -1,
                  longint'(v.expCh));
   endtask

   initial begin
      int                cyc;
      int                acks;
      int                base;
      int                sz;
      int                seenCount;
      logic [NUM_CH-1:0] seen;

      vecs[0] = '{req: 4'b0001, latency: 5, data: 12'h123, expCh: 2'd0};
      vecs[1] = '{req: 4'b1000, latency: 1, data: 12'hFFF, expCh: 2'd3};
      vecs[2] = '{req: 4'b0010, latency: 7, data: 12'h800, expCh: 2'd1};
      vecs[3] = '{req: 4'b0100, latency: 3, data: 12'h5A3, expCh: 2'd2};

      rst_n     = 1'b0;
      req       = '0;
      scan_en   = 1'b0;
      conv_busy = 1'b0;
      for (int i = 0; i < NUM_CH; i++) chModel[i] = '0;
      tick(2);
      checkOutput("resetOutputs",
                  longint'({conv_start, ack, result_valid, result_ch, result_data,
                            scan_miss, err_timeout, conv_ch}), 0);
      checkOutput("resetChData", longint'(ch_data), 0);
      rst_n = 1'b1;
      tick(1);

      // Single request on channel 2: start latency, store latency, data
      $display("[TB] single request");
      engData    = 12'hA5C;
      engLatency = 20;
      req        = 4'b0100;
      waitStart(10, cyc);
      checkOutput("startLatency", cyc, 3);
      checkOutput("startCh", longint'(conv_ch), 2);
      for (int k = 0; k < 60; k++) begin
         tick(1);
         if (conv_done) break;
      end
      checkOutput("storeNotYet", longint'(result_valid), 0);
      tick(1);
      checkOutput("resultValidLatency", longint'(result_valid), 1);
      checkOutput("singleAck", longint'(ack), 4'b0100);
      checkOutput("singleData", longint'(result_data), 12'hA5C);
      req = '0;
      chModel[2] = 12'hA5C;
      checkOutput("singleChData", longint'(ch_data), longint'(packModel()));

      // Table of single requests on every channel
      $display("[TB] vector table");
      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Round-robin with all four requests held
      $display("[TB] round robin");
      applyReset();
      engLatency = 3;
      base = startLog.size();
      req  = 4'b1111;
      acks = 0;
      for (int k = 0; k < 400 && acks < 8; k++) begin
         tick(1);
         if (ack != 0) acks++;
      end
      req = '0;
      tick(30);
      checkOutput("rrAcks", acks, 8);
      checkOutput("rrStarts", startLog.size() - base, 8);
      checkOutput("rrOrder", orderErrors(base, 8), 0);

      // Periodic scan without overrun
      $display("[TB] periodic scan");
      applyReset();
      engLatency = 3;
      base    = startLog.size();
      acks    = missCount;
      scan_en = 1'b1;
      tick(650);
      scan_en = 1'b0;
      tick(20);
      checkOutput("scanConversions", startLog.size() - base, 12);
      checkOutput("scanOrder", orderErrors(base, 12), 0);
      checkOutput("scanNoMiss", missCount - acks, 0);

      // Scan overrun, then scan_en dropped while passes are still queued
      $display("[TB] scan overrun");
      applyReset();
      engLatency = 60;
      base    = startLog.size();
      acks    = missCount;
      scan_en = 1'b1;
      tick(1100);
      scan_en = 1'b0;
      checkOutput("overrunMiss", longint'((missCount - acks) > 0), 1);
      sz = startLog.size();
      tick(400);
      checkOutput("drainContinues", longint'(startLog.size() > sz), 1);
      sz = startLog.size();
      tick(200);
      checkOutput("drainStops", startLog.size(), sz);
      checkOutput("overrunOrder", orderErrors(base, startLog.size() - base), 0);

      // Timeout abort, retry, then conv_done coinciding with the timeout
      $display("[TB] timeout");
      applyReset();
      engRespond = 1'b0;
      req        = 4'b0010;
      waitStart(20, cyc);
      checkOutput("tmoStartCh", longint'(conv_ch), 1);
      seen = '0;
      cyc  = 151;
      for (int k = 1; k <= 150; k++) begin
         tick(1);
         seen = seen | ack;
         if (err_timeout) begin
            cyc = k;
            break;
         end
      end
      checkOutput("tmoCycle", cyc, TIMEOUT);
      checkOutput("tmoNoAck", longint'(seen), 0);
      engRespond = 1'b1;
      engLatency = TIMEOUT - 1;
      engData    = 12'h3C7;
      waitStart(10, cyc);
      checkOutput("retryLatency", cyc, 3);
      checkOutput("retryCh", longint'(conv_ch), 1);
      seenCount = 0;
      cyc       = 151;
      seen      = '0;
      for (int k = 1; k <= 150; k++) begin
         tick(1);
         if (err_timeout) seenCount++;
         if (ack != 0) begin
            cyc  = k;
            seen = ack;
            break;
         end
      end
      req = '0;
      checkOutput("doneWinsAckCycle", cyc, TIMEOUT + 1);
      checkOutput("doneWinsAck", longint'(seen), 4'b0010);
      checkOutput("doneWinsData", longint'(result_data), 12'h3C7);
      checkOutput("doneWinsNoErr", seenCount, 0);

      // conv_busy holds off conv_start
      $display("[TB] busy");
      applyReset();
      engLatency = 5;
      engData    = 12'h777;
      conv_busy  = 1'b1;
      req        = 4'b0001;
      seenCount  = 0;
      for (int k = 0; k < 50; k++) begin
         tick(1);
         if (conv_start) seenCount++;
      end
      checkOutput("busyNoStart", seenCount, 0);
      conv_busy = 1'b0;
      waitStart(10, cyc);
      checkOutput("busyReleaseStart", cyc, 1);
      waitAck(50, cyc, seen);
      req = '0;
      checkOutput("busyAck", longint'(seen), 4'b0001);
      checkOutput("busyChData", longint'(ch_data[DATA_W-1:0]), 12'h777);

      // Reset while waiting for the engine; the late conv_done must be ignored
      $display("[TB] reset in wait");
      engLatency = 40;
      engData    = 12'hBAD;
      req        = 4'b0100;
      waitStart(20, cyc);
      tick(10);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncResetOutputs",
                  longint'({conv_start, ack, result_valid, result_ch, result_data,
                            scan_miss, err_timeout, conv_ch}), 0);
      checkOutput("asyncResetChData", longint'(ch_data), 0);
      req  = '0;
      tick(2);
      rst_n = 1'b1;
      acks = rvCount;
      base = doneCount;
      tick(60);
      checkOutput("lateDoneArrived", doneCount - base, 1);
      checkOutput("lateDoneIgnored", rvCount - acks, 0);
      checkOutput("lateDoneChData", longint'(ch_data), 0);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
